hcms_frame_sequencer: RTL

- Top-level sequencer for an HCMS-29xx dot-matrix display. It drives a byte-serial engine over a load/ready handshake.
- After reset it issues the display reset pulse and writes both control words. On each refresh request it then streams NUM_CHARS*COLS_PER_CHAR column bytes from a column frame buffer.
- It sits between the application logic that fills the frame buffer and the byte serializer that drives the display pins.

---
 rtl/hcms_pkg.sv | 39 +++
 rtl/hcms_frame_sequencer_if.sv | 22 ++
 rtl/hcms_byte_handshake.sv | 50 +++++
 rtl/hcms_frame_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hcms_pkg.sv
// Shared types and constants for the HCMS-29xx frame sequencer and its byte handshake.
package hcms_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_CW0,
    ST_CW1,
    ST_IDLE,
    ST_FETCH,
    ST_XFER,
    ST_WAIT_LOW
  } state_t;

  // Tells WAIT_LOW where to return once the current byte has been handed off.
  typedef enum logic [1:0] {
    PH_CFG0,
    PH_CFG1,
    PH_DOT
  } phase_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_LOAD,
    HS_WAIT_LOW
  } hs_state_t;

  typedef struct packed {
    state_t    state;
    phase_t    phase;
    hs_state_t hs_state;
  } dbg_t;

  localparam logic HCMS_DATA_REGISTER    = 1'b0;
  localparam logic HCMS_COMMAND_REGISTER = 1'b1;

  localparam logic [7:0] DEF_CTRL_WORD0 = 8'h7F;
  localparam logic [7:0] DEF_CTRL_WORD1 = 8'h81;

endpackage

// File: rtl/hcms_frame_sequencer_if.sv
// Byte bus between the frame sequencer (master) and the byte serializer (slave).
interface hcms_frame_sequencer_if;
  // Handshake: master raises o_byte_load with o_byte/o_byte_cmd/o_latch_en stable; the slave
  // raises i_byte_ready when done; master then drops load and waits for ready to fall before
  // the next load. Data fields stay frozen from load rise until ready falls.
  logic [7:0] o_byte;
  logic       o_byte_cmd;
  logic       o_byte_load;
  logic       i_byte_ready;
  logic       o_latch_en;
  logic       o_hcms_reset;

  modport master (
    output o_byte, o_byte_cmd, o_byte_load, o_latch_en, o_hcms_reset,
    input  i_byte_ready
  );

  modport slave (
    input  o_byte, o_byte_cmd, o_byte_load, o_latch_en, o_hcms_reset,
    output i_byte_ready
  );
endinterface

// File: rtl/hcms_byte_handshake.sv
// Load/ready protocol engine: one byte per start pulse, done once ready has fallen again.
module hcms_byte_handshake
  import hcms_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      byte_ready,
  output logic      byte_load,
  output logic      acked,
  output logic      done,
  output hs_state_t hs_state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_state  <= HS_IDLE;
      byte_load <= 1'b0;
      acked     <= 1'b0;
      done      <= 1'b0;
    end else begin
      acked <= 1'b0;
      done  <= 1'b0;
      case (hs_state)
        HS_IDLE: begin
          if (start) begin
            byte_load <= 1'b1;
            hs_state  <= HS_LOAD;
          end
        end
        // load is already visible for this whole cycle, so a ready that was high on entry counts
        HS_LOAD: begin
          if (byte_ready) begin
            byte_load <= 1'b0;
            acked     <= 1'b1;
            hs_state  <= HS_WAIT_LOW;
          end
        end
        HS_WAIT_LOW: begin
          if (!byte_ready) begin
            done     <= 1'b1;
            hs_state <= HS_IDLE;
          end
        end
        default: hs_state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hcms_frame_sequencer.sv
// HCMS-29xx sequencer: display reset, two control words, then column frames on refresh.
module hcms_frame_sequencer
  import hcms_pkg::*;
#(
  parameter int         NUM_CHARS     = 4,
  parameter int         COLS_PER_CHAR = 5,
  parameter int         RESET_CYCLES  = 16,
  parameter logic [7:0] CTRL_WORD0    = DEF_CTRL_WORD0,
  parameter logic [7:0] CTRL_WORD1    = DEF_CTRL_WORD1,
  parameter int         ADDR_W        = 5
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic                  i_refresh,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [ADDR_W-1:0]     o_col_addr,
  input  logic [7:0]            i_col_data,
  hcms_frame_sequencer_if.master bus,
  output dbg_t                  dbg
);

  localparam int                FRAME_LEN = NUM_CHARS * COLS_PER_CHAR;
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(FRAME_LEN - 1);
  localparam int                CNT_W     = $clog2(RESET_CYCLES + 1);

  state_t          state;
  phase_t          phase;
  hs_state_t       hs_state;
  logic            pending;
  logic            fetch_wait;
  logic [CNT_W-1:0] rst_cnt;
  logic            start;
  logic            hs_acked;
  logic            hs_done;
  logic            byte_load;
  logic [7:0]      byte_r;
  logic            cmd_r;
  logic            latch_r;
  logic            hcms_reset_r;

  hcms_byte_handshake u_handshake (
    .clk        (i_CLK),
    .rst        (i_reset),
    .start      (start),
    .byte_ready (bus.i_byte_ready),
    .byte_load  (byte_load),
    .acked      (hs_acked),
    .done       (hs_done),
    .hs_state   (hs_state)
  );

  assign bus.o_byte       = byte_r;
  assign bus.o_byte_cmd   = cmd_r;
  assign bus.o_byte_load  = byte_load;
  assign bus.o_latch_en   = latch_r;
  assign bus.o_hcms_reset = hcms_reset_r;
  assign dbg              = {state, phase, hs_state};

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state        <= ST_RST_HOLD;
      phase        <= PH_CFG0;
      pending      <= 1'b0;
      fetch_wait   <= 1'b0;
      rst_cnt      <= '0;
      start        <= 1'b0;
      byte_r       <= '0;
      cmd_r        <= HCMS_DATA_REGISTER;
      latch_r      <= 1'b1;
      hcms_reset_r <= 1'b1;
      o_busy       <= 1'b1;
      o_frame_done <= 1'b0;
      o_col_addr   <= '0;
    end else begin
      start        <= 1'b0;
      o_frame_done <= 1'b0;
      // Requests arriving while busy coalesce into a single pending frame
      if (i_refresh) pending <= 1'b1;
      case (state)
        ST_RST_HOLD: begin
          if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) begin
            hcms_reset_r <= 1'b0;
            state        <= ST_CW0;
          end else begin
            rst_cnt <= rst_cnt + CNT_W'(1);
          end
        end
        ST_CW0: begin
          byte_r  <= CTRL_WORD0;
          cmd_r   <= HCMS_COMMAND_REGISTER;
          latch_r <= 1'b1;
          phase   <= PH_CFG0;
          start   <= 1'b1;
          state   <= ST_XFER;
        end
        ST_CW1: begin
          byte_r  <= CTRL_WORD1;
          cmd_r   <= HCMS_COMMAND_REGISTER;
          latch_r <= 1'b1;
          phase   <= PH_CFG1;
          start   <= 1'b1;
          state   <= ST_XFER;
        end
        ST_IDLE: begin
          if (pending) begin
            pending    <= 1'b0;
            o_col_addr <= '0;
            o_busy     <= 1'b1;
            phase      <= PH_DOT;
            fetch_wait <= 1'b0;
            state      <= ST_FETCH;
          end
        end
        // First cycle covers the frame-buffer read latency, second captures the column
        ST_FETCH: begin
          if (!fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            fetch_wait <= 1'b0;
            byte_r     <= i_col_data;
            cmd_r      <= HCMS_DATA_REGISTER;
            latch_r    <= (o_col_addr == LAST_COL);
            start      <= 1'b1;
            state      <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (hs_acked) state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (hs_done) begin
            case (phase)
              PH_CFG0: state <= ST_CW1;
              PH_CFG1: begin
                o_busy <= 1'b0;
                state  <= ST_IDLE;
              end
              default: begin
                if (o_col_addr == LAST_COL) begin
                  o_frame_done <= 1'b1;
                  o_busy       <= 1'b0;
                  state        <= ST_IDLE;
                end else begin
                  o_col_addr <= o_col_addr + ADDR_W'(1);
                  state      <= ST_FETCH;
                end
              end
            endcase
          end
        end
        default: state <= ST_RST_HOLD;
      endcase
    end
  end

endmodule
